// File: rtl/median_frame_ctrl_if.sv
// rtl/median_frame_ctrl_if.sv - raw pixel in / filter result in / selected pixel out bundle
interface median_frame_ctrl_if #(
  parameter int DW = 24
);
  logic          Y_de;
  logic          Y_hsync;
  logic          Y_vsync;
  logic [DW-1:0] Y_data;
  logic [DW-1:0] median_data;
  logic          out_de;
  logic          out_hsync;
  logic          out_vsync;
  logic [DW-1:0] out_data;

  modport master (
    output Y_de, Y_hsync, Y_vsync, Y_data, median_data,
    input  out_de, out_hsync, out_vsync, out_data
  );

  modport slave (
    input  Y_de, Y_hsync, Y_vsync, Y_data, median_data,
    output out_de, out_hsync, out_vsync, out_data
  );
endinterface

// File: rtl/median_frame_ctrl.sv
// rtl/median_frame_ctrl.sv - frame sequencer and median/raw output selector for the 3x3 median filter
module median_frame_ctrl #(
  parameter int COL = 1024,
  parameter int ROW = 768,
  parameter int LAT = 4,
  parameter int DW  = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  median_frame_ctrl_if.slave   vid,
  input  logic                 cfg_en,
  input  logic                 err_clr,
  output logic                 en_active,
  output logic                 busy,
  output logic [15:0]          frame_cnt,
  output logic                 err_short,
  output logic                 err_extra
);
  localparam int CW = (COL > 1) ? $clog2(COL) : 1;
  localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COL - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROW - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [RW-1:0] row, row_nxt;
  logic          vs_q, de_q;
  logic          vs_rise, border, sel_in;
  logic          frame_inc, short_ev, extra_ev;

  assign vs_rise = vid.Y_vsync & ~vs_q;
  assign busy    = (state == S_ACTIVE);
  assign border  = (row == '0) | (row == ROW_LAST) | (col == '0) | (col == COL_LAST);
  // A vsync edge restarts the frame, so the pixel in that cycle is never filtered.
  assign sel_in  = en_active & busy & ~vs_rise & ~border;

  always_comb begin
    state_nxt = state;
    col_nxt   = col;
    row_nxt   = row;
    frame_inc = 1'b0;
    short_ev  = 1'b0;
    extra_ev  = 1'b0;
    if (vs_rise) begin
      state_nxt = S_ACTIVE;
      col_nxt   = '0;
      row_nxt   = '0;
    end else begin
      case (state)
        S_ACTIVE: begin
          if (vid.Y_de) begin
            if (col == COL_LAST) begin
              col_nxt = '0;
              if (row == ROW_LAST) begin
                state_nxt = S_DONE;
                frame_inc = 1'b1;
              end else begin
                row_nxt = row + RW'(1);
              end
            end else begin
              col_nxt = col + CW'(1);
            end
          end else if (de_q && (col != '0)) begin
            short_ev = 1'b1;
            col_nxt  = '0;
            if (row == ROW_LAST) state_nxt = S_DONE;
            else                 row_nxt   = row + RW'(1);
          end
        end
        S_DONE:  extra_ev = vid.Y_de;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      vs_q      <= 1'b0;
      de_q      <= 1'b0;
      en_active <= 1'b0;
      frame_cnt <= '0;
      err_short <= 1'b0;
      err_extra <= 1'b0;
    end else begin
      state <= state_nxt;
      col   <= col_nxt;
      row   <= row_nxt;
      vs_q  <= vid.Y_vsync;
      de_q  <= vid.Y_de;
      if (vs_rise)   en_active <= cfg_en;
      if (frame_inc) frame_cnt <= frame_cnt + 16'd1;
      if (short_ev)     err_short <= 1'b1;
      else if (err_clr) err_short <= 1'b0;
      if (extra_ev)     err_extra <= 1'b1;
      else if (err_clr) err_extra <= 1'b0;
    end
  end

  logic          de_tail, hs_tail, vs_tail, sel_tail;
  logic [DW-1:0] data_tail;

  // LAT-1 plain delay stages; the output register below is the LAT-th.
  generate
    if (LAT == 1) begin : g_nopipe
      assign de_tail   = vid.Y_de;
      assign hs_tail   = vid.Y_hsync;
      assign vs_tail   = vid.Y_vsync;
      assign sel_tail  = sel_in;
      assign data_tail = vid.Y_data;
    end else begin : g_pipe
      logic [LAT-2:0] de_p, hs_p, vs_p, sel_p;
      logic [DW-1:0]  data_p [LAT-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          de_p  <= '0;
          hs_p  <= '0;
          vs_p  <= '0;
          sel_p <= '0;
          for (int i = 0; i < LAT - 1; i++) data_p[i] <= '0;
        end else begin
          de_p[0]   <= vid.Y_de;
          hs_p[0]   <= vid.Y_hsync;
          vs_p[0]   <= vid.Y_vsync;
          sel_p[0]  <= sel_in;
          data_p[0] <= vid.Y_data;
          for (int i = 1; i < LAT - 1; i++) begin
            de_p[i]   <= de_p[i-1];
            hs_p[i]   <= hs_p[i-1];
            vs_p[i]   <= vs_p[i-1];
            sel_p[i]  <= sel_p[i-1];
            data_p[i] <= data_p[i-1];
          end
        end
      end

      assign de_tail   = de_p[LAT-2];
      assign hs_tail   = hs_p[LAT-2];
      assign vs_tail   = vs_p[LAT-2];
      assign sel_tail  = sel_p[LAT-2];
      assign data_tail = data_p[LAT-2];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vid.out_de    <= 1'b0;
      vid.out_hsync <= 1'b0;
      vid.out_vsync <= 1'b0;
      vid.out_data  <= '0;
    end else begin
      vid.out_de    <= de_tail;
      vid.out_hsync <= hs_tail;
      vid.out_vsync <= vs_tail;
      if (de_tail) vid.out_data <= sel_tail ? vid.median_data : data_tail;
    end
  end
endmodule

// File: tb/tb_median_frame_ctrl.sv
// tb/tb_median_frame_ctrl.sv - directed scoreboard bench for median_frame_ctrl
module tb_median_frame_ctrl;
  localparam int COL = 8;
  localparam int ROW = 6;
  localparam int LAT = 4;
  localparam int DW  = 24;
  localparam logic [DW-1:0] MED = 24'hAAAAAA;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en;
  logic        err_clr;
  logic        en_active, busy, err_short, err_extra;
  logic [15:0] frame_cnt;

  median_frame_ctrl_if #(.DW(DW)) vid ();

  median_frame_ctrl #(.COL(COL), .ROW(ROW), .LAT(LAT), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .vid       (vid),
    .cfg_en    (cfg_en),
    .err_clr   (err_clr),
    .en_active (en_active),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .err_short (err_short),
    .err_extra (err_extra)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && vid.out_de) begin
      if (exp_q.size() == 0) chk("out_unexpected", 32'd1, 32'd0);
      else                   chk("out_data", 32'(vid.out_data), 32'(exp_q.pop_front()));
    end
  end

  // Inputs are set at a falling edge; returns at the next falling edge.
  task automatic cyc(input logic de, input logic hs, input logic vs,
                     input logic [DW-1:0] d, input logic [DW-1:0] e);
    vid.Y_de    = de;
    vid.Y_hsync = hs;
    vid.Y_vsync = vs;
    vid.Y_data  = d;
    if (de) exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, '0, '0);
  endtask

  task automatic vsync_pulse();
    cyc(1'b0, 1'b0, 1'b1, '0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic pixels(input int r, input int c0, input int n, input bit en, input bit track);
    logic [DW-1:0] d;
    bit b;
    for (int c = c0; c < c0 + n; c++) begin
      d = 24'h550000 | DW'(r << 8) | DW'(c);
      b = (r == 0) || (r == ROW - 1) || (c == 0) || (c == COL - 1);
      cyc(1'b1, 1'b0, 1'b0, d, (en && track && !b) ? MED : d);
    end
  endtask

  task automatic full_frame(input bit en);
    vsync_pulse();
    for (int r = 0; r < ROW; r++) begin
      pixels(r, 0, COL, en, 1'b1);
      blank(2);
    end
  endtask

  initial begin
    rst             = 1'b1;
    cfg_en          = 1'b0;
    err_clr         = 1'b0;
    vid.Y_de        = 1'b0;
    vid.Y_hsync     = 1'b0;
    vid.Y_vsync     = 1'b0;
    vid.Y_data      = '0;
    vid.median_data = MED;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_out_de", 32'(vid.out_de), 32'd0);
    chk("rst_out_data", 32'(vid.out_data), 32'd0);
    chk("rst_en_active", 32'(en_active), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_err_short", 32'(err_short), 32'd0);
    chk("rst_err_extra", 32'(err_extra), 32'd0);

    cfg_en = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 24'h123456, 24'h123456);
    blank(3);
    chk("idle_lat_de", 32'(vid.out_de), 32'd1);
    chk("idle_lat_data", 32'(vid.out_data), 32'h123456);
    blank(2);

    vsync_pulse();
    pixels(0, 0, COL, 1'b1, 1'b1);
    pixels(1, 0, 3, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_out_de", 32'(vid.out_de), 32'd0);
    chk("async_rst_out_data", 32'(vid.out_data), 32'd0);
    chk("async_rst_en_active", 32'(en_active), 32'd0);
    exp_q.delete();
    @(negedge clk);
    blank(2);
    rst = 1'b0;
    blank(1);
    chk("post_rst_busy", 32'(busy), 32'd0);

    cfg_en = 1'b1;
    vsync_pulse();
    chk("norm_en_active", 32'(en_active), 32'd1);
    chk("norm_busy", 32'(busy), 32'd1);
    for (int r = 0; r < ROW - 1; r++) begin
      pixels(r, 0, COL, 1'b1, 1'b1);
      blank(2);
    end
    pixels(ROW - 1, 0, COL - 1, 1'b1, 1'b1);
    chk("norm_busy_before_last", 32'(busy), 32'd1);
    pixels(ROW - 1, COL - 1, 1, 1'b1, 1'b1);
    chk("norm_busy_after_last", 32'(busy), 32'd0);
    chk("norm_frame_cnt", 32'(frame_cnt), 32'd1);
    blank(LAT + 2);
    chk("norm_drained", 32'(exp_q.size()), 32'd0);

    cfg_en = 1'b0;
    vsync_pulse();
    chk("byp_en_active", 32'(en_active), 32'd0);
    for (int r = 0; r < ROW; r++) begin
      if (r == 3) cfg_en = 1'b1;
      pixels(r, 0, COL, 1'b0, 1'b1);
      blank(2);
    end
    chk("byp_en_active_end", 32'(en_active), 32'd0);
    chk("byp_frame_cnt", 32'(frame_cnt), 32'd2);

    vsync_pulse();
    chk("short_en_active", 32'(en_active), 32'd1);
    pixels(0, 0, COL, 1'b1, 1'b1); blank(2);
    pixels(1, 0, COL, 1'b1, 1'b1); blank(2);
    pixels(2, 0, 5, 1'b1, 1'b1);   blank(2);
    chk("short_err", 32'(err_short), 32'd1);
    chk("short_busy_mid", 32'(busy), 32'd1);
    pixels(3, 0, COL, 1'b1, 1'b1); blank(2);
    pixels(4, 0, COL, 1'b1, 1'b1); blank(2);
    pixels(5, 0, 3, 1'b1, 1'b1);   blank(2);
    chk("short_busy_end", 32'(busy), 32'd0);
    chk("short_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("short_no_extra", 32'(err_extra), 32'd0);

    pixels(6, 0, COL, 1'b1, 1'b0);
    blank(2);
    chk("extra_err", 32'(err_extra), 32'd1);
    err_clr = 1'b1;
    pixels(7, 0, 1, 1'b1, 1'b0);
    err_clr = 1'b0;
    chk("extra_clr_collide", 32'(err_extra), 32'd1);
    chk("short_clr_by_collide", 32'(err_short), 32'd0);
    blank(2);
    err_clr = 1'b1;
    blank(1);
    err_clr = 1'b0;
    chk("extra_clr_lone", 32'(err_extra), 32'd0);
    blank(LAT + 2);

    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    chk("wrap_preload", 32'(frame_cnt), 32'hFFFF);
    full_frame(1'b1);
    chk("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) blank(1);
    chk("final_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
